// File: rtl/issue_ctrl_if.sv
// Decoder/issue/write-back bundle for issue_ctrl.
// master: decoder side (drives the in_* instruction fields, observes all results).
// slave : issue_ctrl side (drives in_ready, issue, write-back, scoreboard and stall count).
interface issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        in_use_rs1;
    logic        in_use_rs2;
    logic        in_reg_write;
    logic [3:0]  in_alu_op;
    logic        iss_valid;
    logic        iss_slow;
    logic [3:0]  iss_op;
    logic [4:0]  iss_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_slow;
    logic [31:0] busy_o;
    logic [31:0] stall_cycles;

    modport master (
        output in_valid, in_rd, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_reg_write, in_alu_op,
        input  in_ready, iss_valid, iss_slow, iss_op, iss_rd, wb_valid, wb_rd, wb_slow,
        input  busy_o, stall_cycles
    );

    modport slave (
        input  in_valid, in_rd, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_reg_write, in_alu_op,
        output in_ready, iss_valid, iss_slow, iss_op, iss_rd, wb_valid, wb_rd, wb_slow,
        output busy_o, stall_cycles
    );
endinterface

// File: rtl/issue_ctrl.sv
// In-order issue controller: one decoded instruction per cycle, 32-entry write scoreboard,
// RAW/WAW and write-back collision stalls, one fast single-cycle path plus one
// non-pipelined slow unit (mul/div) sharing a single write-back port.
// Ports:
//   clk   - clock
//   reset - synchronous active-low reset
//   bus   - issue_ctrl_if.slave: in_* decoder handshake, iss_* issue pulse,
//           wb_* write-back, busy_o scoreboard, stall_cycles counter
module issue_ctrl #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 8
) (
    input logic         clk,
    input logic         reset,
    issue_ctrl_if.slave bus
);
    localparam logic [3:0] OpMul = 4'b0011;
    localparam logic [3:0] OpDiv = 4'b0100;

    localparam logic [7:0] MulLat = MUL_LAT[7:0];
    localparam logic [7:0] DivLat = DIV_LAT[7:0];

    logic        iss_valid_q, iss_slow_q, iss_wr_q;
    logic [3:0]  iss_op_q;
    logic [4:0]  iss_rd_q;
    logic        wb_valid_q, wb_slow_q;
    logic [4:0]  wb_rd_q;
    logic        slow_active_q, slow_wr_q;
    logic [7:0]  slow_cnt_q;
    logic [4:0]  slow_rd_q;
    logic [31:0] busy_q, busy_d;
    logic [31:0] stall_q, stall_d;

    logic       is_slow, wr_eff, accept, in_ready;
    logic       slow_fire, fast_fire;
    logic [7:0] lat;

    always_comb begin
        is_slow = (bus.in_alu_op == OpMul) || (bus.in_alu_op == OpDiv);
        lat     = (bus.in_alu_op == OpMul) ? MulLat : DivLat;
        wr_eff  = bus.in_reg_write && (bus.in_rd != 5'd0);

        in_ready = reset
                 && !(bus.in_use_rs1 && busy_q[bus.in_rs1])
                 && !(bus.in_use_rs2 && busy_q[bus.in_rs2])
                 && !(bus.in_reg_write && busy_q[bus.in_rd]);
        if (is_slow) begin
            // A new slow op may enter in the previous one's write-back cycle.
            in_ready = in_ready && (!slow_active_q || (slow_cnt_q == 8'd0));
        end else begin
            // A fast op accepted now would write back exactly when the slow op does.
            in_ready = in_ready && !(slow_active_q && (slow_cnt_q == 8'd2));
        end
        accept = bus.in_valid && in_ready;

        // Write-back registers are loaded one cycle ahead of the wb cycle.
        slow_fire = slow_active_q && (slow_cnt_q == 8'd1);
        fast_fire = iss_valid_q && !iss_slow_q;
    end

    always_comb begin
        busy_d = busy_q;
        if (wb_valid_q) busy_d[wb_rd_q] = 1'b0;
        if (accept && wr_eff) busy_d[bus.in_rd] = 1'b1;
        busy_d[0] = 1'b0;

        stall_d = stall_q;
        if (bus.in_valid && !in_ready && (stall_q != 32'hffff_ffff)) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            iss_valid_q   <= 1'b0;
            iss_slow_q    <= 1'b0;
            iss_wr_q      <= 1'b0;
            iss_op_q      <= 4'd0;
            iss_rd_q      <= 5'd0;
            wb_valid_q    <= 1'b0;
            wb_slow_q     <= 1'b0;
            wb_rd_q       <= 5'd0;
            slow_active_q <= 1'b0;
            slow_wr_q     <= 1'b0;
            slow_cnt_q    <= 8'd0;
            slow_rd_q     <= 5'd0;
            busy_q        <= 32'd0;
            stall_q       <= 32'd0;
        end else begin
            iss_valid_q <= accept;
            if (accept) begin
                iss_slow_q <= is_slow;
                iss_wr_q   <= wr_eff;
                iss_op_q   <= bus.in_alu_op;
                iss_rd_q   <= bus.in_rd;
            end

            if (accept && is_slow) begin
                slow_active_q <= 1'b1;
                slow_cnt_q    <= lat;
                slow_rd_q     <= bus.in_rd;
                slow_wr_q     <= wr_eff;
            end else if (slow_active_q) begin
                if (slow_cnt_q == 8'd0) slow_active_q <= 1'b0;
                else slow_cnt_q <= slow_cnt_q - 8'd1;
            end

            // slow_fire and fast_fire are mutually exclusive by the collision stall.
            wb_valid_q <= (slow_fire && slow_wr_q) || (fast_fire && iss_wr_q);
            if (slow_fire) begin
                wb_rd_q   <= slow_rd_q;
                wb_slow_q <= 1'b1;
            end else if (fast_fire) begin
                wb_rd_q   <= iss_rd_q;
                wb_slow_q <= 1'b0;
            end

            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.iss_valid    = iss_valid_q;
    assign bus.iss_slow     = iss_slow_q;
    assign bus.iss_op       = iss_op_q;
    assign bus.iss_rd       = iss_rd_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_slow      = wb_slow_q;
    assign bus.busy_o       = busy_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: a cycle-indexed event model (accept cycle -> issue and write-back
// cycles, per-register busy-until cycle) checked against the DUT every cycle, plus
// hand-computed literal expectations on recorded observations.
module tb_issue_ctrl;
    localparam int MulLat = 3;
    localparam int DivLat = 8;
    localparam int N      = 1024;

    logic clk;
    logic reset;
    issue_ctrl_if bus();

    issue_ctrl #(.MUL_LAT(MulLat), .DIV_LAT(DivLat)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model state.
    bit         e_iss_v [N];
    bit         e_iss_s [N];
    logic [3:0] e_iss_op[N];
    logic [4:0] e_iss_rd[N];
    bit         e_wb_v  [N];
    bit         e_wb_s  [N];
    logic [4:0] e_wb_rd [N];
    int         busy_until[32];
    int         slow_wb = -1;
    logic [31:0] m_stall = 0;
    bit         m_acc = 0;
    int         m_acc_cyc = -1;

    // Observations for literal checks.
    bit          obs_ready[N];
    bit          obs_iss_v[N];
    bit          obs_iss_s[N];
    bit          obs_wb_v [N];
    bit          obs_wb_s [N];
    logic [4:0]  obs_wb_rd[N];
    logic [31:0] obs_busy [N];
    logic [31:0] obs_stall[N];

    initial for (int r = 0; r < 32; r++) busy_until[r] = -1;

    task automatic chk(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, c, act, exp);
        end
    endtask

    function automatic bit model_ready(input int c);
        bit slow;
        slow = (bus.in_alu_op == 4'd3) || (bus.in_alu_op == 4'd4);
        if (!reset) return 1'b0;
        if (bus.in_use_rs1 && busy_until[bus.in_rs1] >= c) return 1'b0;
        if (bus.in_use_rs2 && busy_until[bus.in_rs2] >= c) return 1'b0;
        if (bus.in_reg_write && busy_until[bus.in_rd] >= c) return 1'b0;
        if (slow) return slow_wb <= c;
        return slow_wb != c + 2;
    endfunction

    int          cc;
    bit          er;
    logic [31:0] eb;

    always @(negedge clk) begin
        if (chk_en) begin
            cc = cyc;
            er = model_ready(cc);
            eb = 32'd0;
            for (int r = 1; r < 32; r++) eb[r] = (busy_until[r] >= cc);

            chk("in_ready", cc, {31'd0, bus.in_ready}, {31'd0, er});
            chk("iss_valid", cc, {31'd0, bus.iss_valid}, {31'd0, e_iss_v[cc]});
            if (e_iss_v[cc]) begin
                chk("iss_op", cc, {28'd0, bus.iss_op}, {28'd0, e_iss_op[cc]});
                chk("iss_rd", cc, {27'd0, bus.iss_rd}, {27'd0, e_iss_rd[cc]});
                chk("iss_slow", cc, {31'd0, bus.iss_slow}, {31'd0, e_iss_s[cc]});
            end
            chk("wb_valid", cc, {31'd0, bus.wb_valid}, {31'd0, e_wb_v[cc]});
            if (e_wb_v[cc]) begin
                chk("wb_rd", cc, {27'd0, bus.wb_rd}, {27'd0, e_wb_rd[cc]});
                chk("wb_slow", cc, {31'd0, bus.wb_slow}, {31'd0, e_wb_s[cc]});
            end
            chk("busy_o", cc, bus.busy_o, eb);
            chk("stall_cycles", cc, bus.stall_cycles, m_stall);

            obs_ready[cc] = bus.in_ready;
            obs_iss_v[cc] = bus.iss_valid;
            obs_iss_s[cc] = bus.iss_slow;
            obs_wb_v[cc]  = bus.wb_valid;
            obs_wb_s[cc]  = bus.wb_slow;
            obs_wb_rd[cc] = bus.wb_rd;
            obs_busy[cc]  = bus.busy_o;
            obs_stall[cc] = bus.stall_cycles;

            m_acc = 1'b0;
            if (!reset) begin
                for (int k = cc + 1; k < cc + 16 && k < N; k++) begin
                    e_iss_v[k] = 1'b0;
                    e_wb_v[k]  = 1'b0;
                end
                for (int r = 0; r < 32; r++) busy_until[r] = -1;
                slow_wb = -1;
                m_stall = 32'd0;
            end else if (bus.in_valid) begin
                if (!er) begin
                    if (m_stall != 32'hffff_ffff) m_stall = m_stall + 1;
                end else begin
                    bit slow;
                    int wb;
                    slow = (bus.in_alu_op == 4'd3) || (bus.in_alu_op == 4'd4);
                    wb   = slow ? cc + 1 + ((bus.in_alu_op == 4'd3) ? MulLat : DivLat) : cc + 2;
                    e_iss_v[cc+1]  = 1'b1;
                    e_iss_s[cc+1]  = slow;
                    e_iss_op[cc+1] = bus.in_alu_op;
                    e_iss_rd[cc+1] = bus.in_rd;
                    if (bus.in_reg_write && bus.in_rd != 5'd0) begin
                        e_wb_v[wb]            = 1'b1;
                        e_wb_rd[wb]           = bus.in_rd;
                        e_wb_s[wb]            = slow;
                        busy_until[bus.in_rd] = wb;
                    end
                    if (slow) slow_wb = wb;
                    m_acc     = 1'b1;
                    m_acc_cyc = cc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_to(input int t);
        bus.in_valid = 1'b0;
        while (cyc < t) tick();
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic send(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit u1, input bit u2, input bit wr, input logic [3:0] op,
                        output int acc);
        int n;
        bus.in_rd = rd;  bus.in_rs1 = rs1;  bus.in_rs2 = rs2;
        bus.in_use_rs1 = u1;  bus.in_use_rs2 = u2;  bus.in_reg_write = wr;
        bus.in_alu_op = op;  bus.in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 100);
        acc = m_acc ? m_acc_cyc : -1;
        if (!m_acc) chk("send_timeout", cyc, 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

    int a0, a1;

    initial begin
        reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_rd = 5'd0;  bus.in_rs1 = 5'd0;  bus.in_rs2 = 5'd0;
        bus.in_use_rs1 = 1'b0;  bus.in_use_rs2 = 1'b0;  bus.in_reg_write = 1'b0;
        bus.in_alu_op = 4'd0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        // Reset held with in_valid=1 during cycles 1..3.
        tick(); tick(); tick();
        chk("rst_outputs", cyc,
            {bus.iss_valid, bus.iss_slow, bus.iss_op, bus.iss_rd, bus.wb_valid, bus.wb_slow,
             bus.wb_rd, 14'd0}, 32'd0);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        idle_to(6);
        chk("rst_ready_low", 2, {31'd0, obs_ready[2]}, 32'd0);
        chk("rst_ready_low3", 3, {31'd0, obs_ready[3]}, 32'd0);
        chk("rst_stall", 3, obs_stall[3], 32'd0);
        chk("rst_release", 4, {31'd0, obs_ready[4]}, 32'd1);

        // Back-to-back fast.
        do_reset();
        send(5'd1, 5'd2, 5'd3, 1, 1, 1, 4'd0, a0);
        send(5'd4, 5'd5, 5'd6, 1, 1, 1, 4'd0, a1);
        idle_to(a0 + 6);
        chk("b2b_acc", a1, a1, a0 + 1);
        chk("b2b_iss1", a0 + 1, {31'd0, obs_iss_v[a0+1]}, 32'd1);
        chk("b2b_iss2", a0 + 2, {31'd0, obs_iss_v[a0+2]}, 32'd1);
        chk("b2b_wb1", a0 + 2, {26'd0, obs_wb_v[a0+2], obs_wb_rd[a0+2]}, {26'd0, 1'b1, 5'd1});
        chk("b2b_wb4", a0 + 3, {26'd0, obs_wb_v[a0+3], obs_wb_rd[a0+3]}, {26'd0, 1'b1, 5'd4});

        // RAW stall.
        do_reset();
        send(5'd1, 5'd2, 5'd3, 1, 1, 1, 4'd0, a0);
        send(5'd7, 5'd1, 5'd2, 1, 1, 1, 4'd0, a1);
        idle_to(a1 + 4);
        chk("raw_acc", a1, a1, a0 + 3);
        chk("raw_stall1", a0 + 1, {31'd0, obs_ready[a0+1]}, 32'd0);
        chk("raw_stall2", a0 + 2, {31'd0, obs_ready[a0+2]}, 32'd0);
        chk("raw_busy", a0 + 1, obs_busy[a0+1], 32'h0000_0002);
        chk("raw_count", a1 + 1, obs_stall[a1+1], 32'd2);

        // Mul dependency.
        do_reset();
        send(5'd5, 5'd1, 5'd2, 1, 1, 1, 4'd3, a0);
        send(5'd6, 5'd5, 5'd0, 1, 0, 1, 4'd0, a1);
        idle_to(a1 + 4);
        chk("mul_iss_slow", a0 + 1, {30'd0, obs_iss_v[a0+1], obs_iss_s[a0+1]}, 32'd3);
        chk("mul_wb", a0 + 4, {25'd0, obs_wb_v[a0+4], obs_wb_s[a0+4], obs_wb_rd[a0+4]},
            {25'd0, 1'b1, 1'b1, 5'd5});
        chk("mul_dep_acc", a1, a1, a0 + 5);

        // Collision with an independent fast op.
        do_reset();
        send(5'd5, 5'd1, 5'd2, 1, 1, 1, 4'd3, a0);
        idle_to(a0 + 2);
        send(5'd9, 5'd10, 5'd0, 1, 0, 1, 4'd0, a1);
        idle_to(a1 + 4);
        chk("col_block", a0 + 2, {31'd0, obs_ready[a0+2]}, 32'd0);
        chk("col_acc", a1, a1, a0 + 3);
        chk("col_wb5", a0 + 4, {25'd0, obs_wb_v[a0+4], obs_wb_s[a0+4], obs_wb_rd[a0+4]},
            {25'd0, 1'b1, 1'b1, 5'd5});
        chk("col_wb9", a0 + 5, {25'd0, obs_wb_v[a0+5], obs_wb_s[a0+5], obs_wb_rd[a0+5]},
            {25'd0, 1'b1, 1'b0, 5'd9});

        // Div behind mul waits until the mul write-back cycle.
        do_reset();
        send(5'd5, 5'd1, 5'd2, 1, 1, 1, 4'd3, a0);
        send(5'd10, 5'd11, 5'd12, 1, 1, 1, 4'd4, a1);
        idle_to(a1 + 12);
        chk("div_acc", a1, a1, a0 + 4);
        chk("div_wb", a1 + 9, {25'd0, obs_wb_v[a1+9], obs_wb_s[a1+9], obs_wb_rd[a1+9]},
            {25'd0, 1'b1, 1'b1, 5'd10});

        // x0 destination: issue slot used, no write-back, no busy bit.
        do_reset();
        send(5'd0, 5'd1, 5'd2, 1, 1, 1, 4'd0, a0);
        idle_to(a0 + 4);
        chk("x0_iss", a0 + 1, {31'd0, obs_iss_v[a0+1]}, 32'd1);
        chk("x0_nowb", a0 + 2, {31'd0, obs_wb_v[a0+2]}, 32'd0);

        // Reset mid-operation.
        do_reset();
        send(5'd8, 5'd1, 5'd2, 1, 1, 1, 4'd4, a0);
        idle_to(a0 + 3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        idle_to(a0 + 11);
        chk("mid_busy_before", a0 + 2, obs_busy[a0+2], 32'h0000_0100);
        for (int k = a0 + 4; k <= a0 + 9; k++) begin
            chk("mid_no_wb", k, {31'd0, obs_wb_v[k]}, 32'd0);
            chk("mid_busy_clr", k, obs_busy[k], 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
